// File: rtl/i2c_slave_regfile_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile_pkg
//   Shared definitions for the I2C register-file slave and its bus front end:
//   - state_e                : slave protocol state encoding
//   - COND_START / COND_STOP : bus-condition patterns over
//                              {scl_prev, scl_now, sda_prev, sda_now}
//   - DEFAULT_SLAVE_ADDR     : 7-bit device address used when none is given
//   - ack_exit_state()       : where an ACK slot leads once it has completed
// ---------------------------------------------------------------------------
package i2c_slave_regfile_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK
  } state_e;

  // SCL held high on both samples while SDA moves: falling is START, rising
  // is STOP.
  localparam logic [3:0] COND_START = 4'b11_10;
  localparam logic [3:0] COND_STOP  = 4'b11_01;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

  // State entered on the SCL fall that ends a slave-driven ACK bit.
  function automatic state_e ack_exit_state(input state_e s, input logic rw);
    state_e nxt;
    nxt = ST_IDLE;
    case (s)
      ST_ADDR_ACK:  nxt = rw ? ST_READ : ST_PTR;
      ST_PTR_ACK:   nxt = ST_WRITE;
      ST_WRITE_ACK: nxt = ST_WRITE;
      default:      nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
//   Brings SCL/SDA into the clk domain and derives bus events.
//   Each line passes through a 2-flop synchronizer, followed by one more
//   registered copy that is compared against it for edge detection.
//   Ports:
//     clk, rst (async, active-low)
//     SCL_I, SDA_I        raw bus lines
//     scl, sda            synchronized levels
//     scl_rise, scl_fall  one-clk SCL edge strobes
//     start_det, stop_det one-clk START / STOP strobes
// ---------------------------------------------------------------------------
module i2c_bus_sync
  import i2c_slave_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic SCL_I,
  input  logic SDA_I,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic r_scl_meta, r_scl_sync, r_scl_d;
  logic r_sda_meta, r_sda_sync, r_sda_d;
  logic [3:0] w_cond;

  // Reset to 1 so that an idle (pulled-up) bus produces no spurious edges
  // once reset is released.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_meta <= SCL_I;
      r_scl_sync <= r_scl_meta;
      r_scl_d    <= r_scl_sync;
      r_sda_meta <= SDA_I;
      r_sda_sync <= r_sda_meta;
      r_sda_d    <= r_sda_sync;
    end
  end

  assign w_cond    = {r_scl_d, r_scl_sync, r_sda_d, r_sda_sync};

  assign scl       = r_scl_sync;
  assign sda       = r_sda_sync;
  assign scl_rise  =  r_scl_sync & ~r_scl_d;
  assign scl_fall  = ~r_scl_sync &  r_scl_d;
  assign start_det = (w_cond == COND_START);
  assign stop_det  = (w_cond == COND_STOP);

endmodule

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
//   Addressable I2C slave with a 2^ADDR_W x 8 register file. After a matching
//   address byte, a write transfer loads the register pointer from the first
//   data byte and then writes auto-incrementing registers; a read transfer
//   returns auto-incrementing registers starting at the current pointer.
//   Every register write is mirrored on wr_pulse/wr_addr/wr_data.
//   Ports:
//     clk, rst (async, active-low)
//     SCL_I, SDA_I  bus lines as seen on the wire
//     SDA_O         open-drain drive (0 = pull low, 1 = release)
//     wr_pulse      one-clk strobe per register write
//     wr_addr       index of the last write
//     wr_data       data of the last write
//     busy          addressed transaction in progress
// ---------------------------------------------------------------------------
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL_I,
  input  logic              SDA_I,
  output logic              SDA_O,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Bus front end
  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_unused;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .SCL_I     (SCL_I),
    .SDA_I     (SDA_I),
    .scl       (w_scl),
    .sda       (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  // The synced SCL level is not needed here: its edges carry all timing.
  assign w_unused = w_scl;

  // Protocol state
  state_e            r_state;
  logic [3:0]        r_bit_cnt;   // bits left to receive, or to place on SDA
  logic [7:0]        r_shift;
  logic              r_rw;
  logic              r_ack_drv;   // ACK slot: 0 = waiting for first fall
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [DEPTH];

  // Registered outputs
  logic              r_sda_o;
  logic              r_wr_pulse;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_busy;

  logic [7:0]        w_byte_in;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [7:0]        w_rd_byte;
  logic [7:0]        w_rd_next;

  // Byte as it stands once the bit being sampled right now is shifted in.
  assign w_byte_in = {r_shift[6:0], w_sda};
  // Natural wrap at 2^ADDR_W comes from the pointer width.
  assign w_ptr_inc = r_ptr + ADDR_W'(1);
  assign w_rd_byte = r_regs[r_ptr];
  assign w_rd_next = r_regs[w_ptr_inc];

  // START/STOP override every state; otherwise each state reacts only to
  // synced SCL edges, so SDA_O can change only on an SCL fall.
  // NOTE: the register file is cleared by the asynchronous reset like any
  // other flop, because a reset must return every register to 0; this keeps
  // it in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_ptr      <= '0;
      r_sda_o    <= 1'b1;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wr_pulse <= 1'b0;

      if (w_start) begin
        // Plain or repeated START: always restart address reception.
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd7;
        r_sda_o   <= 1'b1;
      end else if (w_stop) begin
        // Any partially received byte is simply dropped.
        r_state <= ST_IDLE;
        r_sda_o <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_sda_o <= 1'b1;
          end

          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte_in;
              if (r_bit_cnt == 4'd0) begin
                if (w_byte_in[7:1] == SLAVE_ADDR) begin
                  r_rw      <= w_byte_in[0];
                  r_ack_drv <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_ADDR_ACK;
                end else begin
                  // Not ours: stay off the bus until the next START.
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end
            end
          end

          ST_PTR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte_in;
              if (r_bit_cnt == 4'd0) begin
                r_ptr     <= w_byte_in[ADDR_W-1:0];
                r_ack_drv <= 1'b0;
                r_state   <= ST_PTR_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end
            end
          end

          ST_WRITE: begin
            if (w_scl_rise) begin
              r_shift <= w_byte_in;
              if (r_bit_cnt == 4'd0) begin
                r_regs[r_ptr] <= w_byte_in;
                r_wr_pulse    <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte_in;
                r_ptr         <= w_ptr_inc;
                r_ack_drv     <= 1'b0;
                r_state       <= ST_WRITE_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: begin
            // First fall (end of bit 8) pulls SDA low; second fall (end of
            // the ACK bit) leaves the slot.
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_o   <= 1'b0;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 4'd7;
                r_state   <= ack_exit_state(r_state, r_rw);
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  // This same fall also places the MSB of the first byte.
                  r_sda_o <= w_rd_byte[7];
                  r_shift <= {w_rd_byte[6:0], 1'b0};
                end else begin
                  r_sda_o <= 1'b1;
                end
              end
            end
          end

          ST_READ: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd0) begin
                // Bit 0 has been clocked out: hand SDA to the master.
                r_sda_o <= 1'b1;
                r_state <= ST_READ_ACK;
              end else begin
                r_sda_o   <= r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end
            end
          end

          ST_READ_ACK: begin
            if (w_scl_rise) begin
              r_ptr <= w_ptr_inc;
              if (!w_sda) begin
                // ACK: all 8 bits of the next byte are still to be placed,
                // starting on the fall that ends this ACK bit.
                r_shift   <= w_rd_next;
                r_bit_cnt <= 4'd8;
                r_state   <= ST_READ;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end

          default: begin
            r_sda_o <= 1'b1;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign SDA_O    = r_sda_o;
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regfile
//   Bit-banged I2C master driving i2c_slave_regfile over a wired-AND SDA line.
//   Expected ACKs, read bytes and register-write strobes are queued when the
//   stimulus is issued; monitor processes compare them against what the DUT
//   presents on the bus and on its write-strobe port.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regfile;

  localparam int ADDR_W = 4;
  localparam int Q      = 5;   // clk cycles per SCL quarter phase

  logic              clk;
  logic              rst;
  logic              m_scl;
  logic              m_sda;
  logic              sda_bus;
  logic              dut_sda_o;
  logic              dut_wr_pulse;
  logic [ADDR_W-1:0] dut_wr_addr;
  logic [7:0]        dut_wr_data;
  logic              dut_busy;

  assign sda_bus = m_sda & dut_sda_o;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .SCL_I    (m_scl),
    .SDA_I    (sda_bus),
    .SDA_O    (dut_sda_o),
    .wr_pulse (dut_wr_pulse),
    .wr_addr  (dut_wr_addr),
    .wr_data  (dut_wr_data),
    .busy     (dut_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard storage
  typedef struct {
    string name;
    int    value;
  } bus_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_exp_t;

  bus_exp_t bus_exp_q[$];
  int       bus_obs_q[$];
  wr_exp_t  wr_exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic sda_watch = 1'b0;
  int   sda_low_cnt = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Write-strobe monitor
  always @(negedge clk) begin : wr_mon
    wr_exp_t e;
    if (rst === 1'b1 && dut_wr_pulse === 1'b1) begin
      if (wr_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_pulse_unexpected: got addr %0d data 0x%0h, expected no strobe",
                 dut_wr_addr, dut_wr_data);
      end else begin
        e = wr_exp_q.pop_front();
        check("wr_addr", 32'(dut_wr_addr), 32'(e.addr));
        check("wr_data", 32'(dut_wr_data), 32'(e.data));
      end
    end
  end

  // Bus monitor: compares ACK bits and read bytes captured on the wire.
  always @(negedge clk) begin : bus_mon
    bus_exp_t e;
    int       obs;
    while (bus_obs_q.size() > 0) begin
      obs = bus_obs_q.pop_front();
      if (bus_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL bus_unexpected: got 0x%0h, expected nothing", obs);
      end else begin
        e = bus_exp_q.pop_front();
        check(e.name, 32'(obs), 32'(e.value));
      end
    end
  end

  // SDA must stay released while the slave is not addressed.
  always @(negedge clk) begin
    if (sda_watch && dut_sda_o !== 1'b1) sda_low_cnt++;
  end

  // Master bus primitives
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                           input string name);
    logic ack;
    bus_exp_q.push_back('{name, int'(exp_ack)});
    for (int i = 7; i >= 0; i--) clock_bit(b[i]);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    ack = sda_bus;
    m_scl = 1'b0; wait_clk(Q);
    bus_obs_q.push_back(int'(ack));
  endtask

  task automatic recv_byte(input logic [7:0] exp_data, input logic m_ack,
                           input string name);
    logic [7:0] d;
    bus_exp_q.push_back('{name, int'(exp_data)});
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      d[i] = sda_bus;
      m_scl = 1'b0;
    end
    wait_clk(1);
    m_sda = m_ack; wait_clk(Q);
    m_scl = 1'b1;  wait_clk(Q);
    m_scl = 1'b0;  wait_clk(1);
    m_sda = 1'b1;
    bus_obs_q.push_back(int'(d));
  endtask

  // Watchdog: every wait above is time-bounded, this is a last resort.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(4);

    // Reset state
    check("reset_sda_o",    32'(dut_sda_o),    32'd1);
    check("reset_wr_pulse", 32'(dut_wr_pulse), 32'd0);
    check("reset_wr_addr",  32'(dut_wr_addr),  32'd0);
    check("reset_wr_data",  32'(dut_wr_data),  32'd0);
    check("reset_busy",     32'(dut_busy),     32'd0);
    rst = 1'b1;
    wait_clk(4);

    // Write 0xA5, 0x5A starting at register 3
    bus_start();
    send_byte(8'hA0, 1'b0, "wr_addr_ack");
    check("busy_after_match", 32'(dut_busy), 32'd1);
    send_byte(8'h03, 1'b0, "wr_ptr_ack");
    wr_exp_q.push_back('{4'd3, 8'hA5});
    send_byte(8'hA5, 1'b0, "wr_d0_ack");
    wr_exp_q.push_back('{4'd4, 8'h5A});
    send_byte(8'h5A, 1'b0, "wr_d1_ack");
    bus_stop();
    check("busy_after_stop", 32'(dut_busy), 32'd0);

    // Random read from register 3
    bus_start();
    send_byte(8'hA0, 1'b0, "rr_addr_ack");
    send_byte(8'h03, 1'b0, "rr_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "rr_raddr_ack");
    recv_byte(8'hA5, 1'b0, "rr_byte0");
    recv_byte(8'h5A, 1'b1, "rr_byte1");
    check("rr_busy_after_nack", 32'(dut_busy), 32'd0);
    bus_stop();
    check("rr_busy_after_stop", 32'(dut_busy), 32'd0);

    // Address mismatch: no ACK, SDA never pulled, no strobe
    sda_low_cnt = 0;
    sda_watch   = 1'b1;
    bus_start();
    send_byte(8'hA2, 1'b1, "mm_addr_nack");
    check("mm_busy", 32'(dut_busy), 32'd0);
    send_byte(8'h11, 1'b1, "mm_data_nack");
    bus_stop();
    sda_watch = 1'b0;
    check("mm_sda_quiet", 32'(sda_low_cnt), 32'd0);

    // Pointer wrap on write: 15 -> 0
    bus_start();
    send_byte(8'hA0, 1'b0, "wrap_addr_ack");
    send_byte(8'h0F, 1'b0, "wrap_ptr_ack");
    wr_exp_q.push_back('{4'd15, 8'h11});
    send_byte(8'h11, 1'b0, "wrap_d0_ack");
    wr_exp_q.push_back('{4'd0, 8'h22});
    send_byte(8'h22, 1'b0, "wrap_d1_ack");
    bus_stop();

    // Pointer wrap on read: 15, 0, 1
    bus_start();
    send_byte(8'hA0, 1'b0, "wrr_addr_ack");
    send_byte(8'h0F, 1'b0, "wrr_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "wrr_raddr_ack");
    recv_byte(8'h11, 1'b0, "wrr_byte15");
    recv_byte(8'h22, 1'b0, "wrr_byte0");
    recv_byte(8'h00, 1'b1, "wrr_byte1");
    bus_stop();

    // STOP after 5 bits of a write leaves the register untouched
    bus_start();
    send_byte(8'hA0, 1'b0, "sm_pre_addr_ack");
    send_byte(8'h05, 1'b0, "sm_pre_ptr_ack");
    wr_exp_q.push_back('{4'd5, 8'h3C});
    send_byte(8'h3C, 1'b0, "sm_pre_data_ack");
    bus_stop();
    bus_start();
    send_byte(8'hA0, 1'b0, "sm_addr_ack");
    send_byte(8'h05, 1'b0, "sm_ptr_ack");
    for (int i = 0; i < 5; i++) clock_bit(1'b1);
    bus_stop();
    check("sm_busy", 32'(dut_busy), 32'd0);
    bus_start();
    send_byte(8'hA0, 1'b0, "sm_rd_addr_ack");
    send_byte(8'h05, 1'b0, "sm_rd_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "sm_rd_raddr_ack");
    recv_byte(8'h3C, 1'b1, "sm_rd_byte5");
    bus_stop();

    // Reset while the slave drives a 0 during a read of 0xA5
    bus_start();
    send_byte(8'hA0, 1'b0, "rst_addr_ack");
    send_byte(8'h03, 1'b0, "rst_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "rst_raddr_ack");
    check("rst_pre_bit7", 32'(dut_sda_o), 32'd1);
    clock_bit(1'b1);
    check("rst_pre_bit6_low", 32'(dut_sda_o), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_sda_o", 32'(dut_sda_o), 32'd1);
    check("rst_async_busy",  32'(dut_busy),  32'd0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    bus_start();
    send_byte(8'hA0, 1'b0, "post_addr_ack");
    send_byte(8'h03, 1'b0, "post_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "post_raddr_ack");
    recv_byte(8'h00, 1'b0, "post_byte3");
    recv_byte(8'h00, 1'b1, "post_byte4");
    bus_stop();

    wait_clk(10);
    check("bus_queue_drained", 32'(bus_exp_q.size()), 32'd0);
    check("wr_queue_drained",  32'(wr_exp_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
